// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle word stream: type codes, field layout
// and LFSR helpers used by the streamer and by its consumers.
package obstacle_pkg;

    localparam int NUM_LANES = 3;
    localparam int TYPE_MSB  = 15;
    localparam int LANE_LSB  = 11;
    localparam int DEPTH_W   = 11;

    // OBS_RAMP2 exists only in row storage; it leaves the block as OBS_RAMP1
    typedef enum logic [2:0] {
        OBS_EMPTY = 3'b000,
        OBS_LOW   = 3'b001,
        OBS_HIGH  = 3'b010,
        OBS_MID   = 3'b011,
        OBS_TRAIN = 3'b100,
        OBS_RAMP1 = 3'b101,
        OBS_RAMP2 = 3'b111
    } obs_type_e;

    typedef logic [NUM_LANES-1:0][2:0] row_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [2:0] lfsr_type(input logic [2:0] b);
        case (b)
            3'b110:  return OBS_EMPTY;
            3'b111:  return OBS_RAMP1;
            default: return b;
        endcase
    endfunction

    function automatic logic [1:0] lane_next(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

endpackage

// File: rtl/obstacle_streamer_row_generator.sv
// Builds the next row entering the window and owns the generator LFSR,
// which advances once per generated row.
module row_generator
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  row_t top_row,
    input  logic safe,
    output row_t new_row
);

    logic [15:0]          lfsr;
    logic [NUM_LANES-1:0] forced;
    row_t                 gen;
    logic [1:0]           pass;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (step)
            lfsr <= lfsr_next(lfsr);
    end

    always_comb begin
        forced = '0;
        gen    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            case (top_row[l])
                OBS_RAMP1: begin gen[l] = OBS_RAMP2; forced[l] = 1'b1; end
                OBS_RAMP2: begin gen[l] = OBS_TRAIN; forced[l] = 1'b1; end
                default:   gen[l] = lfsr_type(lfsr[3*l +: 3]);
            endcase
        end
        // pass lane walks past ramp continuations; at least one lane is always free
        pass = (lfsr[15:14] == 2'd3) ? 2'd0 : lfsr[15:14];
        if (forced[pass]) begin
            pass = lane_next(pass);
            if (forced[pass])
                pass = lane_next(pass);
        end
        new_row       = gen;
        new_row[pass] = OBS_EMPTY;
        if (safe)
            new_row = '0;
    end

endmodule

// File: rtl/obstacle_streamer.sv
// Scrolling obstacle window plus the per-frame scan that streams one word
// per lane per row, row 0 first.
module obstacle_streamer
    import obstacle_pkg::*;
#(
    parameter int          HALF_BLOCK_LENGTH = 64,
    parameter int          SPEED             = 4,
    parameter int          NUM_ROWS          = 8,
    parameter int          SAFE_ROWS         = 3,
    parameter logic [15:0] SEED              = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        game_over,
    output logic [15:0] obstacle,
    output logic        obstacle_valid,
    output logic        firstrow,
    output logic        scan_busy
);

    localparam int PW = $clog2(HALF_BLOCK_LENGTH);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int SW = (SAFE_ROWS > 0) ? $clog2(SAFE_ROWS + 1) : 1;
    localparam logic [PW-1:0] LAST_P   = PW'(HALF_BLOCK_LENGTH - SPEED);
    localparam logic [PW-1:0] STEP_P   = PW'(SPEED);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam int            DEPTH_MAX = (1 << DEPTH_W) - 1;

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                 state, state_d;
    row_t [NUM_ROWS-1:0]    rows, rows_d;
    row_t                   new_row;
    logic [PW-1:0]          progress, prog_d;
    logic [SW-1:0]          safe_cnt, safe_d;
    logic                   scroll, shift, emit;
    logic [RW-1:0]          ptr_row, ptr_row_d, word_row;
    logic [1:0]             ptr_lane, ptr_lane_d, word_lane;
    logic [2:0]             wtype, otype;
    logic [15:0]            word;
    int                     depth;

    row_generator #(.SEED(SEED)) u_gen (
        .clk     (clk),
        .rst     (rst),
        .step    (shift),
        .top_row (rows[NUM_ROWS-1]),
        .safe    (safe_cnt != '0),
        .new_row (new_row)
    );

    always_comb begin
        scroll = new_frame && !game_over;
        shift  = scroll && (progress >= LAST_P);
        prog_d = progress;
        rows_d = rows;
        safe_d = safe_cnt;
        if (shift) begin
            prog_d = '0;
            rows_d = {new_row, rows[NUM_ROWS-1:1]};
            if (safe_cnt != '0)
                safe_d = safe_cnt - 1'b1;
        end else if (scroll) begin
            prog_d = progress + STEP_P;
        end
    end

    // a new_frame always (re)starts the scan at row 0 and emits that word next cycle
    always_comb begin
        state_d    = state;
        emit       = 1'b0;
        word_row   = ptr_row;
        word_lane  = ptr_lane;
        ptr_row_d  = ptr_row;
        ptr_lane_d = ptr_lane;
        if (new_frame) begin
            emit      = 1'b1;
            word_row  = '0;
            word_lane = '0;
        end else if (state == SCAN) begin
            emit = 1'b1;
        end
        if (emit) begin
            if (word_lane == 2'd2) begin
                ptr_lane_d = 2'd0;
                ptr_row_d  = word_row + 1'b1;
            end else begin
                ptr_lane_d = word_lane + 2'd1;
                ptr_row_d  = word_row;
            end
            state_d = (word_row == LAST_ROW && word_lane == 2'd2) ? IDLE : SCAN;
        end
    end

    // words are taken from the post-scroll window so a frame sees its own update
    always_comb begin
        wtype = rows_d[word_row][word_lane];
        otype = (wtype == OBS_RAMP2) ? OBS_RAMP1 : wtype;
        depth = (int'(word_row) + 1) * HALF_BLOCK_LENGTH - 1 - int'(prog_d);
        if (wtype == OBS_RAMP1)
            depth = depth + HALF_BLOCK_LENGTH;
        if (depth > DEPTH_MAX)
            depth = DEPTH_MAX;
        word = {otype, word_lane, DEPTH_W'(depth)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr_row        <= '0;
            ptr_lane       <= '0;
            rows           <= '0;
            progress       <= '0;
            safe_cnt       <= SW'(SAFE_ROWS);
            obstacle       <= '0;
            obstacle_valid <= 1'b0;
            firstrow       <= 1'b0;
            scan_busy      <= 1'b0;
        end else begin
            state          <= state_d;
            ptr_row        <= ptr_row_d;
            ptr_lane       <= ptr_lane_d;
            rows           <= rows_d;
            progress       <= prog_d;
            safe_cnt       <= safe_d;
            obstacle       <= emit ? word : '0;
            obstacle_valid <= emit;
            firstrow       <= emit && (word_row == '0);
            scan_busy      <= emit;
        end
    end

endmodule

// File: doc/obstacle_streamer.md
Name: obstacle_streamer

Overview:
- Producer end of the 16-bit obstacle word stream that the game logic and renderer consume.
- Holds a scrolling window of NUM_ROWS half-block rows × 3 lanes and advances it SPEED score points per frame, in lockstep with the player's progress.
- Generates new rows with an LFSR.
- After each new_frame, emits one obstacle word per lane per row, marking row-0 words with firstrow.

Parameters:
- HALF_BLOCK_LENGTH, 64, score points per row; power of two.
- SPEED, 4, score points advanced per frame; must divide HALF_BLOCK_LENGTH.
- NUM_ROWS, 8, rows held in the window (2..16).
- SAFE_ROWS, 3, rows forced empty after reset.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- new_frame  in  1  one-cycle frame strobe
- game_over  in  1  freezes scrolling and generation while high
- obstacle  out  16  [15:13] type, [12:11] lane, [10:0] depth
- obstacle_valid  out  1  obstacle word valid this cycle
- firstrow  out  1  word belongs to row 0 (the player's row)
- scan_busy  out  1  high while a frame scan is in progress

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - obstacle=0, obstacle_valid=0, firstrow=0, scan_busy=0.
  - progress=0, lfsr=SEED, state=IDLE.
  - All rows empty (type 000). safe_cnt=SAFE_ROWS.
- Internal row storage is 3 bits per lane:
  - 000 empty, 001 low barrier, 010 high barrier, 011 middle barrier, 100 train, 101 ramp first half, 111 ramp second half.
  - 111 is output as 101.
- Scroll, on the new_frame cycle when game_over=0:
  - If progress < HALF_BLOCK_LENGTH-SPEED, progress += SPEED.
  - Otherwise progress=0, rows shift down one (row 0 discarded), and a generated row loads into row NUM_ROWS-1. The LFSR steps once per generated row.
  - If game_over=1, progress, rows and LFSR hold. The scan still runs.
- Generation, for each lane of the new row:
  - If the lane's previous top row is 101, the lane is forced to 111.
  - Otherwise, if the previous top row is 111, the lane is forced to 100.
  - Otherwise the type comes from LFSR bits {3 per lane}: 110 maps to 000, and 111 maps to 101.
  - Pass lane = lfsr[15:14] mod 3. It is forced to 000 unless a ramp continuation is forced in it, in which case the next lane mod 3 is used.
  - While safe_cnt > 0, all lanes are 000 and safe_cnt decrements.
- Depth field, with r = row index and p = progress after the update:
  - depth = (r+1)*HALF_BLOCK_LENGTH - 1 - p.
  - For type 101 (ramp first half), depth additionally gets +HALF_BLOCK_LENGTH.
  - Row 0 depths therefore fall in 0..63, and a first-half ramp in row 0 falls in 64..127.
  - Width is 11 bits. Depth saturates at 2047.
- Scan state machine, IDLE → SCAN → IDLE:
  - IDLE→SCAN on new_frame (game_over is irrelevant).
  - In SCAN, one word is output per cycle in order row 0..NUM_ROWS-1, lane 0..2. Outputs are registered.
  - The first valid word appears 1 cycle after the new_frame cycle. The scan lasts exactly 3*NUM_ROWS cycles with obstacle_valid=1 on every cycle.
  - firstrow=1 only for the 3 row-0 words.
  - SCAN→IDLE after the last word. obstacle_valid drops the next cycle.
  - Words reflect state after that frame's scroll.
- Boundaries:
  - new_frame during SCAN: the scroll applies, the scan aborts and restarts at row 0 next cycle. No word is duplicated in the same cycle.
  - rst mid-scan: all outputs return to reset values on the next edge.
  - The frame period must be at least 3*NUM_ROWS+2 cycles. A shorter period is a usage error.
  - Lane values are always 0..2. Lane encoding 3 is never emitted.

Decomposition:
- Shared package obstacle_pkg contains:
  - The 3-bit type enum, including the internal ramp-second-half code.
  - Field-position constants TYPE_MSB=15, LANE_LSB=11, DEPTH_W=11.
  - NUM_LANES=3.
- This package is also imported by the consumers.
- One sub-module, row_generator: combinational new-row builder from the previous top row, lfsr and safe_cnt, plus the registered 16-bit LFSR.

Test Plan:
- Reset, then new_frame → 24 consecutive valid words starting 1 cycle later. The first 3 have firstrow=1, lanes 0,1,2, type 000, depth 63-4=59. Rows 0..2 are all 000.
- 16 new_frames (SPEED=4) → on the 16th frame the rows shift; row 0 words show depth 63 and the window contents are the previous rows 1..7.
- Preload via 100+ frames, checking every generated row → each row has at least one 000 lane; every 101 is followed in that lane by 111 then 100; no lane value 3 is emitted.
- game_over=1, then 5 new_frames → identical 24-word scans each frame; progress and depths unchanged.
- new_frame asserted at scan word 10 → that scan aborts, a new scan starts at row 0 next cycle, and 24 words follow.
- A ramp first half reaching row 0 with p=20 → word type 101, firstrow=1, depth 107. The next row-shift gives the same lane type 101 (from 111) at depth 63.
